// File: rtl/mem_access_stage_if.sv
// EX/MEM inputs, data-memory handshake and MEM/WB outputs of the memory-access stage.
// The slave modport is the stage; the master modport is the surrounding pipeline and memory.
interface mem_access_stage_if;
    logic        ex_mem_valid;
    logic        ex_mem_mem_read;
    logic        ex_mem_mem_write;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_wdata;
    logic        ex_mem_reg_write;
    logic        ex_mem_mem_to_reg;
    logic [4:0]  ex_mem_dest_reg;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    logic        mem_stall;
    logic        mem_wb_reg_write;
    logic        mem_wb_mem_to_reg;
    logic [31:0] mem_wb_alu_result;
    logic [31:0] mem_wb_read_data;
    logic [4:0]  mem_wb_dest_reg;
    logic        mem_err;

    modport slave (
        input  ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write, ex_mem_alu_result,
               ex_mem_wdata, ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_dest_reg,
               dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall,
               mem_wb_reg_write, mem_wb_mem_to_reg, mem_wb_alu_result,
               mem_wb_read_data, mem_wb_dest_reg, mem_err
    );

    modport master (
        output ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write, ex_mem_alu_result,
               ex_mem_wdata, ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_dest_reg,
               dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall,
               mem_wb_reg_write, mem_wb_mem_to_reg, mem_wb_alu_result,
               mem_wb_read_data, mem_wb_dest_reg, mem_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: passes ALU ops straight to MEM/WB, runs loads/stores over a
// req/ack data-memory port with a bounded wait, and raises a sticky error on faults.
module mem_access_stage #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_access_stage_if.slave    bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        lat_reg_write_q, lat_reg_write_d;
    logic        lat_mem_to_reg_q, lat_mem_to_reg_d;
    logic [4:0]  lat_dest_q, lat_dest_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [31:0] wb_alu_result_q, wb_alu_result_d;
    logic [31:0] wb_read_data_q, wb_read_data_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic        err_q, err_d;
    logic        stall_c;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        we_d             = we_q;
        lat_reg_write_d  = lat_reg_write_q;
        lat_mem_to_reg_d = lat_mem_to_reg_q;
        lat_dest_d       = lat_dest_q;
        wb_reg_write_d   = wb_reg_write_q;
        wb_mem_to_reg_d  = wb_mem_to_reg_q;
        wb_alu_result_d  = wb_alu_result_q;
        wb_read_data_d   = wb_read_data_q;
        wb_dest_d        = wb_dest_q;
        err_d            = err_q;
        stall_c          = 1'b0;

        case (state_q)
            IDLE: begin
                // A bubble only clears the write enables; data fields keep their last values.
                wb_reg_write_d  = 1'b0;
                wb_mem_to_reg_d = 1'b0;
                if (bus.ex_mem_valid) begin
                    if (bus.ex_mem_mem_read && bus.ex_mem_mem_write) begin
                        err_d = 1'b1;
                    end else if (bus.ex_mem_mem_read || bus.ex_mem_mem_write) begin
                        addr_d           = bus.ex_mem_alu_result;
                        wdata_d          = bus.ex_mem_wdata;
                        we_d             = bus.ex_mem_mem_write;
                        lat_reg_write_d  = bus.ex_mem_reg_write;
                        lat_mem_to_reg_d = bus.ex_mem_mem_to_reg;
                        lat_dest_d       = bus.ex_mem_dest_reg;
                        cnt_d            = 8'd0;
                        state_d          = ACCESS;
                        stall_c          = 1'b1;
                    end else begin
                        wb_reg_write_d  = bus.ex_mem_reg_write;
                        wb_mem_to_reg_d = bus.ex_mem_mem_to_reg;
                        wb_alu_result_d = bus.ex_mem_alu_result;
                        wb_dest_d       = bus.ex_mem_dest_reg;
                    end
                end
            end
            ACCESS: begin
                if (bus.dmem_ack) begin
                    wb_reg_write_d  = lat_reg_write_q;
                    wb_mem_to_reg_d = lat_mem_to_reg_q;
                    wb_alu_result_d = addr_q;
                    wb_dest_d       = lat_dest_q;
                    if (!we_q) begin
                        wb_read_data_d = bus.dmem_rdata;
                    end
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == LIMIT) begin
                        err_d           = 1'b1;
                        wb_reg_write_d  = 1'b0;
                        wb_mem_to_reg_d = 1'b0;
                        state_d         = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= 8'd0;
            addr_q           <= 32'd0;
            wdata_q          <= 32'd0;
            we_q             <= 1'b0;
            lat_reg_write_q  <= 1'b0;
            lat_mem_to_reg_q <= 1'b0;
            lat_dest_q       <= 5'd0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_alu_result_q  <= 32'd0;
            wb_read_data_q   <= 32'd0;
            wb_dest_q        <= 5'd0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            we_q             <= we_d;
            lat_reg_write_q  <= lat_reg_write_d;
            lat_mem_to_reg_q <= lat_mem_to_reg_d;
            lat_dest_q       <= lat_dest_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_mem_to_reg_q  <= wb_mem_to_reg_d;
            wb_alu_result_q  <= wb_alu_result_d;
            wb_read_data_q   <= wb_read_data_d;
            wb_dest_q        <= wb_dest_d;
            err_q            <= err_d;
        end
    end

    // Request and write strobe follow the state flop, so an async reset drops them at once.
    assign bus.dmem_req          = (state_q == ACCESS);
    assign bus.dmem_we           = we_q && (state_q == ACCESS);
    assign bus.dmem_addr         = addr_q;
    assign bus.dmem_wdata        = wdata_q;
    assign bus.mem_stall         = stall_c && !reset;
    assign bus.mem_wb_reg_write  = wb_reg_write_q;
    assign bus.mem_wb_mem_to_reg = wb_mem_to_reg_q;
    assign bus.mem_wb_alu_result = wb_alu_result_q;
    assign bus.mem_wb_read_data  = wb_read_data_q;
    assign bus.mem_wb_dest_reg   = wb_dest_q;
    assign bus.mem_err           = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: the driver pushes expected MEM/WB contents, a
// monitor pops and compares each time an instruction leaves EX/MEM (valid and not stalled).
module tb_mem_access_stage;
    logic clk;
    logic reset;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  dest;
    } wb_t;

    wb_t exp_q[$];
    int  total  = 0;
    int  passed = 0;
    int  txn    = 0;

    // reference model of what MEM/WB should currently hold
    logic [31:0] m_alu, m_rd;
    logic [4:0]  m_dest;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // monitor: an instruction retires at a rising edge where valid=1 and stall=0
    always begin
        logic fire;
        wb_t  act, exp;
        @(negedge clk);
        fire = !reset && bus.ex_mem_valid && !bus.mem_stall;
        @(posedge clk);
        #2;
        if (fire) begin
            act = {bus.mem_wb_reg_write, bus.mem_wb_mem_to_reg, bus.mem_wb_alu_result,
                   bus.mem_wb_read_data, bus.mem_wb_dest_reg};
            total++;
            txn++;
            if (exp_q.size() == 0) begin
                $display("FAIL txn%0d: retirement with empty scoreboard, got rw=%0b mtr=%0b alu=%08h rd=%08h dst=%0d",
                         txn, act.rw, act.mtr, act.alu, act.rd, act.dest);
            end else begin
                exp = exp_q.pop_front();
                if (act === exp) begin
                    passed++;
                    $display("txn%0d ok: rw=%0b mtr=%0b alu=%08h rd=%08h dst=%0d",
                             txn, act.rw, act.mtr, act.alu, act.rd, act.dest);
                end else begin
                    $display("FAIL txn%0d: got rw=%0b mtr=%0b alu=%08h rd=%08h dst=%0d expected rw=%0b mtr=%0b alu=%08h rd=%08h dst=%0d",
                             txn, act.rw, act.mtr, act.alu, act.rd, act.dest,
                             exp.rw, exp.mtr, exp.alu, exp.rd, exp.dest);
                end
            end
        end
    end

    // ack_delay: N>=0 ack on the Nth ACCESS cycle, -1 never ack, -2 hold ack high while IDLE
    task automatic do_op(input string name, input logic rd, input logic wr, input logic rw,
                         input logic mtr, input logic [31:0] alu, input logic [31:0] wdata,
                         input logic [4:0] dest, input int ack_delay, input logic [31:0] rdata);
        int  exp_stall, exp_req, exp_we, stalls, reqs, we_cyc, acc;
        bit  timeout_exp, retire, done, bad_bus;
        exp_stall = 0; exp_req = 0; exp_we = 0; timeout_exp = 0;
        if (rd && wr) begin
            exp_q.push_back('{1'b0, 1'b0, m_alu, m_rd, m_dest});
            m_err = 1'b1;
        end else if (rd || wr) begin
            if (ack_delay >= 0 && ack_delay <= 15) begin
                exp_req   = ack_delay + 1;
                exp_stall = ack_delay + 1;
                m_alu  = alu;
                m_dest = dest;
                if (rd) m_rd = rdata;
                exp_q.push_back('{rw, mtr, m_alu, m_rd, m_dest});
            end else begin
                exp_req     = 16;
                exp_stall   = 17;
                timeout_exp = 1;
                m_err       = 1'b1;
            end
            exp_we = wr ? exp_req : 0;
        end else begin
            m_alu  = alu;
            m_dest = dest;
            exp_q.push_back('{rw, mtr, m_alu, m_rd, m_dest});
        end

        bus.ex_mem_valid      = 1'b1;
        bus.ex_mem_mem_read   = rd;
        bus.ex_mem_mem_write  = wr;
        bus.ex_mem_alu_result = alu;
        bus.ex_mem_wdata      = wdata;
        bus.ex_mem_reg_write  = rw;
        bus.ex_mem_mem_to_reg = mtr;
        bus.ex_mem_dest_reg   = dest;

        stalls = 0; reqs = 0; we_cyc = 0; acc = 0; done = 0; bad_bus = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (bus.dmem_req) bus.dmem_ack = (acc == ack_delay);
            else              bus.dmem_ack = (ack_delay == -2);
            bus.dmem_rdata = bus.dmem_ack ? rdata : 32'h0;
            @(negedge clk);
            if (bus.mem_stall) stalls++;
            retire = bus.ex_mem_valid && !bus.mem_stall;
            if (bus.dmem_req) begin
                reqs++;
                acc++;
                if (bus.dmem_we) we_cyc++;
                if (bus.dmem_addr !== alu || (wr && bus.dmem_wdata !== wdata)) bad_bus = 1;
            end
            @(posedge clk);
            #1;
            if (retire || (reqs > 0 && !bus.dmem_req)) done = 1;
        end
        bus.ex_mem_valid = 1'b0;
        bus.dmem_ack     = 1'b0;
        bus.dmem_rdata   = 32'h0;
        if (!done) $display("FAIL %s_done: got 0 expected 1 (cycle budget expired)", name);
        total++; if (done) passed++;

        check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({name, "_req_cycles"},   32'(reqs),   32'(exp_req));
        check({name, "_we_cycles"},    32'(we_cyc), 32'(exp_we));
        check({name, "_bus_stable"},   32'(bad_bus), 32'd0);
        check({name, "_mem_err"},      32'(bus.mem_err), 32'(m_err));
        if (timeout_exp) check({name, "_bubble_rw"}, 32'(bus.mem_wb_reg_write), 32'd0);
        $display("op %s: stalls=%0d reqs=%0d we=%0d err=%0b", name, stalls, reqs, we_cyc, bus.mem_err);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_req"},   32'(bus.dmem_req), 32'd0);
        check({name, "_we"},    32'(bus.dmem_we), 32'd0);
        check({name, "_addr"},  bus.dmem_addr, 32'd0);
        check({name, "_wdata"}, bus.dmem_wdata, 32'd0);
        check({name, "_stall"}, 32'(bus.mem_stall), 32'd0);
        check({name, "_wb"},    {26'd0, bus.mem_wb_reg_write, bus.mem_wb_mem_to_reg, bus.mem_wb_dest_reg}, 32'd0);
        check({name, "_wb_alu"}, bus.mem_wb_alu_result, 32'd0);
        check({name, "_wb_rd"}, bus.mem_wb_read_data, 32'd0);
        check({name, "_err"},   32'(bus.mem_err), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.ex_mem_valid = 1'b0; bus.ex_mem_mem_read = 1'b0; bus.ex_mem_mem_write = 1'b0;
        bus.ex_mem_alu_result = 32'h0; bus.ex_mem_wdata = 32'h0; bus.ex_mem_reg_write = 1'b0;
        bus.ex_mem_mem_to_reg = 1'b0; bus.ex_mem_dest_reg = 5'd0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        m_alu = 32'h0; m_rd = 32'h0; m_dest = 5'd0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        do_op("alu",       1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,          5'd5,  0,  32'h0);
        do_op("load3",     1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0,          5'd7,  3,  32'hDEAD_BEEF);
        do_op("store0",    1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h1234_5678,  5'd0,  0,  32'h0);
        do_op("alu_ack",   1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 32'h0,          5'd9,  -2, 32'hBAD0_0BAD);
        do_op("load_lim",  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0304, 32'h0,          5'd3,  15, 32'h0BAD_F00D);
        do_op("load_to",   1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0,          5'd4,  -1, 32'h0);
        do_op("alu_after", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0055, 32'h0,          5'd11, 0,  32'h0);
        do_op("rw_both",   1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0,          5'd12, 0,  32'h0);

        // reset in the middle of an unacknowledged load
        bus.ex_mem_valid = 1'b1; bus.ex_mem_mem_read = 1'b1; bus.ex_mem_mem_write = 1'b0;
        bus.ex_mem_alu_result = 32'h0000_0600; bus.ex_mem_reg_write = 1'b1;
        bus.ex_mem_mem_to_reg = 1'b1; bus.ex_mem_dest_reg = 5'd13; bus.dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midacc_req_before", 32'(bus.dmem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midacc");
        bus.ex_mem_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_alu = 32'h0; m_rd = 32'h0; m_dest = 5'd0; m_err = 1'b0;

        do_op("load_post", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0700, 32'h0,          5'd14, 1,  32'h5A5A_A5A5);

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, max dmem wait cycles before timeout (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ex_mem_valid  input  1  instruction present in EX/MEM.
REQ-005 SHALL have ports ex_mem_mem_read, ex_mem_mem_write  input  1 each  load / store request.
REQ-006 SHALL have port ex_mem_alu_result  input  32  ALU result; memory byte address for loads/stores.
REQ-007 SHALL have port ex_mem_wdata  input  32  store data (forwarded operand 2 from EX).
REQ-008 SHALL have ports ex_mem_reg_write, ex_mem_mem_to_reg  input  1 each; ex_mem_dest_reg  input  5.
REQ-009 SHALL have ports dmem_req, dmem_we  output  1 each; dmem_addr, dmem_wdata  output  32 each.
REQ-010 SHALL have ports dmem_ack  input  1; dmem_rdata  input  32  (rdata valid only when dmem_ack=1).
REQ-011 SHALL have port mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-012 SHALL have ports mem_wb_reg_write, mem_wb_mem_to_reg  output  1 each; mem_wb_alu_result, mem_wb_read_data  output  32 each; mem_wb_dest_reg  output  5.
REQ-013 SHALL have port mem_err  output  1  sticky error flag.

Function
REQ-014 SHALL implement FSM states IDLE and ACCESS; wait counter 8 bits.
REQ-015 IDLE, ex_mem_valid=1 and exactly one of read/write set: SHALL latch address, wdata, we=write and control/dest fields, clear counter, enter ACCESS, load bubble (mem_wb_reg_write=0, mem_wb_mem_to_reg=0) into MEM/WB.
REQ-016 IDLE, ex_mem_valid=1, no memory op: SHALL load all MEM/WB outputs from EX/MEM in one cycle; mem_wb_read_data holds previous value.
REQ-017 IDLE, ex_mem_valid=0: SHALL load bubble into MEM/WB.
REQ-018 IDLE, valid with both read and write set: SHALL set mem_err, load bubble, stay IDLE, no dmem_req.
REQ-019 mem_stall SHALL be combinational: 1 when (IDLE and REQ-015 condition) or (ACCESS and dmem_ack=0); else 0.
REQ-020 dmem_req SHALL be 1 exactly while in ACCESS; dmem_addr/dmem_wdata/dmem_we SHALL be latched values, stable for the whole ACCESS period.
REQ-021 ACCESS, dmem_ack=1: SHALL load MEM/WB from latched fields, mem_wb_read_data=dmem_rdata for loads (unchanged for stores), return IDLE.
REQ-022 ACCESS, dmem_ack=0: SHALL increment counter; when counter equals WAIT_LIMIT SHALL set mem_err, load bubble, return IDLE (dmem_req low next cycle).
REQ-023 dmem_ack and timeout in same cycle: ack SHALL win, mem_err unchanged.
REQ-024 dmem_ack in IDLE SHALL be ignored.
REQ-025 Latency: non-memory op 1 cycle; memory op 2 + N cycles to MEM/WB, N = ack wait cycles; mem_stall high 1 + N cycles.
REQ-026 dmem_addr SHALL be full 32-bit value; no alignment check, no byte enables.
REQ-027 mem_err SHALL be sticky, cleared only by reset.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, counter 0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, all mem_wb_* outputs 0, mem_err=0.
REQ-029 reset during ACCESS SHALL drop dmem_req within the same cycle, abandon the access, produce no MEM/WB write.
REQ-030 mem_stall SHALL be 0 while reset=1.

Verification
REQ-031 ALU op, alu_result=0x0000_0010, reg_write=1, dest=5 -> next edge mem_wb_alu_result=0x10, reg_write=1, dest=5; mem_stall=0 throughout.
REQ-032 Load addr 0x0000_0100, ack 3 cycles after dmem_req with rdata 0xDEAD_BEEF -> mem_stall high 4 cycles, dmem_addr=0x100 stable, mem_wb_read_data=0xDEADBEEF, mem_to_reg=1.
REQ-033 Store addr 0x200, wdata 0x1234_5678, ack first ACCESS cycle -> dmem_we=1, dmem_wdata=0x12345678 one cycle, stall 1 cycle, mem_wb_reg_write=0.
REQ-034 WAIT_LIMIT=15, load never acked -> dmem_req high 16 cycles, mem_err=1, bubble, IDLE; next ALU op passes normally, mem_err stays 1.
REQ-035 Ack on cycle counter=WAIT_LIMIT -> load completes, mem_err=0.
REQ-036 reset asserted mid-ACCESS -> dmem_req=0 and all outputs 0 immediately; after release, new load completes normally.
